// File: rtl/macc_pkg.sv
// rtl/macc_pkg.sv - shared constants and round/shift/saturate helpers for the MAC path
//
// Contents:
//   ACC_W      accumulator width of the DSP48E product/accumulator (48)
//   sat_res_t  saturated value (low out_w bits meaningful) plus saturation bit
//   round_add  sign-extend to ACC_W+1 bits and add half an output LSB
//   shift_sat  arithmetic shift of a rounded value, then clamp to out_w signed bits
//   round_sat  round_add followed by shift_sat in one call
package macc_pkg;

  localparam int ACC_W = 48;

  typedef struct packed {
    logic [ACC_W-1:0] val;
    logic             sat;
  } sat_res_t;

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  function automatic logic signed [ACC_W:0] round_add(input logic [ACC_W-1:0] acc,
                                                      input int shift);
    logic signed [ACC_W:0] ext;
    ext = $signed({acc[ACC_W-1], acc});
    return ext + $signed((ACC_W + 1)'(1) << (shift - 1));
  endfunction

  function automatic sat_res_t shift_sat(input logic signed [ACC_W:0] r,
                                         input int shift, input int out_w);
    logic signed [ACC_W:0] s;
    logic signed [ACC_W:0] max_v;
    logic signed [ACC_W:0] min_v;
    sat_res_t res;
    s     = r >>> shift;
    max_v = $signed(((ACC_W + 1)'(1) << (out_w - 1)) - (ACC_W + 1)'(1));
    min_v = ~max_v;
    res.val = s[ACC_W-1:0];
    res.sat = 1'b0;
    if (s > max_v) begin
      res.val = max_v[ACC_W-1:0];
      res.sat = 1'b1;
    end else if (s < min_v) begin
      res.val = min_v[ACC_W-1:0];
      res.sat = 1'b1;
    end
    return res;
  endfunction

  function automatic sat_res_t round_sat(input logic [ACC_W-1:0] acc,
                                         input int shift, input int out_w);
    return shift_sat(round_add(acc, shift), shift, out_w);
  endfunction

endpackage

// File: rtl/fifo2_vr.sv
// rtl/fifo2_vr.sv - 2-entry valid/ready FIFO with registered head and drop indication
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data this cycle (never stalls the producer)
//   push_data   data to write
//   rdy         consumer accepts dout this cycle
//   dout        head entry, forced to 0 while empty
//   dout_vld    head entry is valid
//   drop        push while full with no pop; the pushed word is discarded
module fifo2_vr #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         rdy,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  output logic         drop
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   count;
  logic         pop;

  assign dout_vld = (count != 2'd0);
  assign dout     = head;
  assign pop      = dout_vld & rdy;
  assign drop     = push & (count == 2'd2) & ~pop;

  // head is cleared whenever the FIFO drains so dout reads 0 while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= push_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= push_data;
          end else if (pop) begin
            head  <= '0;
            count <= 2'd0;
          end else if (push) begin
            tail  <= push_data;
            count <= 2'd2;
          end
        end
        2'd2: begin
          if (push && pop) begin
            head <= tail;
            tail <= push_data;
          end else if (pop) begin
            head  <= tail;
            tail  <= '0;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/macc_dump_sat.sv
// rtl/macc_dump_sat.sv - block counter, capture delay line and round/saturate output stage
//
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   SAMPLE_VLD   MAC accepted a sample this cycle
//   ACC_IN       48-bit signed accumulator from the MAC
//   ACC_CLR      next sample must load rather than accumulate
//   DOUT         OUT_W-bit signed rounded/saturated result (0 when empty)
//   DOUT_VLD     DOUT holds a valid result
//   DOUT_RDY     consumer accepts DOUT
//   SAT_FLAG     sticky: a result saturated
//   DROP_FLAG    sticky: a result was lost to a full output buffer
//   CLR_FLAGS    clear both sticky flags (an event in the same cycle wins)
module macc_dump_sat
  import macc_pkg::*;
#(
  parameter int TAPS     = 16,
  parameter int MACC_LAT = 3,
  parameter int SHIFT    = 17,
  parameter int OUT_W    = 18,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SAMPLE_VLD,
  input  logic [ACC_W-1:0] ACC_IN,
  output logic             ACC_CLR,
  output logic [OUT_W-1:0] DOUT,
  output logic             DOUT_VLD,
  input  logic             DOUT_RDY,
  output logic             SAT_FLAG,
  output logic             DROP_FLAG,
  input  logic             CLR_FLAGS
);

  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   last;
  logic [MACC_LAT-1:0]    tok;
  logic                   capture;
  logic                   v1;
  logic signed [ACC_W:0]  r1;
  sat_res_t               st2;
  logic                   sat_evt;
  logic                   drop_evt;
  logic [ACC_W-OUT_W-1:0] unused_hi;

  assign last = SAMPLE_VLD && (cnt == CNT_W'(TAPS - 1));

  always_comb begin
    cnt_nxt = cnt;
    if (SAMPLE_VLD) begin
      cnt_nxt = last ? '0 : cnt + CNT_W'(1);
    end
  end

  // ACC_CLR is registered from the next count so it always equals (cnt == 0).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      ACC_CLR <= 1'b1;
    end else begin
      cnt     <= cnt_nxt;
      ACC_CLR <= (cnt_nxt == '0);
    end
  end

  // One bit per cycle of MAC latency; several blocks may be in flight at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tok <= '0;
    end else begin
      tok[0] <= last;
      for (int i = 1; i < MACC_LAT; i++) begin
        tok[i] <= tok[i-1];
      end
    end
  end

  assign capture = tok[MACC_LAT-1];

  // Stage 1: round half up while the accumulator holds the finished block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else begin
      v1 <= capture;
      if (capture) begin
        r1 <= round_add(ACC_IN, SHIFT);
      end
    end
  end

  // Stage 2: shift and clamp, pushed straight into the output buffer.
  always_comb begin
    st2 = shift_sat(r1, SHIFT, OUT_W);
  end

  assign unused_hi = st2.val[ACC_W-1:OUT_W];
  assign sat_evt   = v1 & st2.sat;

  fifo2_vr #(
    .W(OUT_W)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (v1),
    .push_data(st2.val[OUT_W-1:0]),
    .rdy      (DOUT_RDY),
    .dout     (DOUT),
    .dout_vld (DOUT_VLD),
    .drop     (drop_evt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SAT_FLAG  <= 1'b0;
      DROP_FLAG <= 1'b0;
    end else begin
      SAT_FLAG  <= sat_evt | (SAT_FLAG & ~CLR_FLAGS);
      DROP_FLAG <= drop_evt | (DROP_FLAG & ~CLR_FLAGS);
    end
  end

endmodule

// File: tb/tb_macc_dump_sat.sv
// tb/tb_macc_dump_sat.sv - self-checking bench for macc_dump_sat
module tb_macc_dump_sat;

  localparam int TAPS     = 4;
  localparam int MACC_LAT = 3;
  localparam int SHIFT    = 8;
  localparam int OUT_W    = 18;
  localparam int CNT_W    = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             SAMPLE_VLD;
  logic [47:0]      ACC_IN;
  logic             ACC_CLR;
  logic [OUT_W-1:0] DOUT;
  logic             DOUT_VLD;
  logic             DOUT_RDY;
  logic             SAT_FLAG;
  logic             DROP_FLAG;
  logic             CLR_FLAGS;

  macc_dump_sat #(
    .TAPS(TAPS), .MACC_LAT(MACC_LAT), .SHIFT(SHIFT), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SAMPLE_VLD(SAMPLE_VLD),
    .ACC_IN    (ACC_IN),
    .ACC_CLR   (ACC_CLR),
    .DOUT      (DOUT),
    .DOUT_VLD  (DOUT_VLD),
    .DOUT_RDY  (DOUT_RDY),
    .SAT_FLAG  (SAT_FLAG),
    .DROP_FLAG (DROP_FLAG),
    .CLR_FLAGS (CLR_FLAGS)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor((v + 2^(SHIFT-1)) / 2^SHIFT), clamped to the signed output range.
  function automatic void ref_rs(input logic [47:0] acc, output logic [OUT_W-1:0] v,
                                 output bit s);
    longint a, t, d, q, hi, lo;
    logic [63:0] qb;
    a  = $signed(acc);
    d  = longint'(1) << SHIFT;
    t  = a + d / 2;
    q  = t / d;
    if (t < 0 && (t % d) != 0) q = q - 1;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    s  = 1'b0;
    if (q > hi) begin
      q = hi;
      s = 1'b1;
    end else if (q < lo) begin
      q = lo;
      s = 1'b1;
    end
    qb = q;
    v  = qb[OUT_W-1:0];
  endfunction

  // Transaction model: every TAPS-th sample schedules a capture MACC_LAT cycles
  // later; each capture delivers one result to a 2-deep output queue next cycle.
  typedef struct {
    int               cyc;
    logic [OUT_W-1:0] val;
    bit               sat;
  } push_t;

  push_t            pend_q[$];
  int               cap_q[$];
  logic [OUT_W-1:0] fq[$];
  int               n_smp;
  int               cyc;
  bit               m_sat, m_drop;
  bit               m_pop, m_push, m_se, m_de, m_rs;
  logic [OUT_W-1:0] m_pv, m_rv;
  push_t            m_e;
  int               pops = 0;
  bit               chk_en = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_smp = 0;
      cyc   = 0;
      cap_q.delete();
      pend_q.delete();
      fq.delete();
      m_sat  = 1'b0;
      m_drop = 1'b0;
    end else begin
      m_pop  = (fq.size() > 0) && DOUT_RDY;
      m_push = 1'b0;
      m_se   = 1'b0;
      m_de   = 1'b0;
      m_pv   = '0;
      if (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
        m_push = 1'b1;
        m_pv   = pend_q[0].val;
        m_se   = pend_q[0].sat;
        void'(pend_q.pop_front());
      end
      if (m_push && fq.size() == 2 && !m_pop) begin
        m_de = 1'b1;
      end else begin
        if (m_pop) void'(fq.pop_front());
        if (m_push) fq.push_back(m_pv);
      end
      if (CLR_FLAGS) begin
        m_sat  = m_se;
        m_drop = m_de;
      end else begin
        m_sat  = m_sat | m_se;
        m_drop = m_drop | m_de;
      end
      if (cap_q.size() > 0 && cap_q[0] == cyc) begin
        ref_rs(ACC_IN, m_rv, m_rs);
        m_e.cyc = cyc + 1;
        m_e.val = m_rv;
        m_e.sat = m_rs;
        pend_q.push_back(m_e);
        void'(cap_q.pop_front());
      end
      if (SAMPLE_VLD) begin
        n_smp++;
        if (n_smp == TAPS) begin
          n_smp = 0;
          cap_q.push_back(cyc + MACC_LAT);
        end
      end
      cyc++;
    end
  end

  always @(negedge CLK) begin
    if (!RST && chk_en) begin
      check("dout_vld", 48'(DOUT_VLD), 48'(fq.size() > 0));
      check("dout", 48'(DOUT), 48'((fq.size() > 0) ? fq[0] : '0));
      check("acc_clr", 48'(ACC_CLR), 48'(n_smp == 0));
      check("sat_flag", 48'(SAT_FLAG), 48'(m_sat));
      check("drop_flag", 48'(DROP_FLAG), 48'(m_drop));
      if (DOUT_VLD && DOUT_RDY) pops++;
    end
  end

  task automatic tick(input logic sv, input logic [47:0] acc);
    SAMPLE_VLD = sv;
    ACC_IN     = acc;
    @(posedge CLK);
    #1;
  endtask

  task automatic block(input logic [47:0] acc, input int idle);
    for (int i = 0; i < TAPS; i++) tick(1'b1, acc);
    for (int i = 0; i < idle; i++) tick(1'b0, acc);
  endtask

  typedef struct {
    logic [47:0]      acc;
    logic [OUT_W-1:0] dout;
    bit               sat;
  } vec_t;

  vec_t        vt[10];
  int          p0;
  logic [63:0] r64;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{48'h0000_0001_2380, 18'h00124, 1'b0};
    vt[1] = '{48'hFFFF_FFFF_FF80, 18'h00000, 1'b0};
    vt[2] = '{48'hFFFF_FFFF_FF7F, 18'h3FFFF, 1'b0};
    vt[3] = '{48'h0000_0000_007F, 18'h00000, 1'b0};
    vt[4] = '{48'h0000_0000_0080, 18'h00001, 1'b0};
    vt[5] = '{48'h0000_01FF_FF7F, 18'h1FFFF, 1'b0};
    vt[6] = '{48'hFFFF_FE00_0000, 18'h20000, 1'b0};
    vt[7] = '{48'h0000_01FF_FF80, 18'h1FFFF, 1'b1};
    vt[8] = '{48'hFFFF_FDFF_FF7F, 18'h20000, 1'b1};
    vt[9] = '{48'h0000_4000_0000, 18'h1FFFF, 1'b1};

    RST = 1'b1; SAMPLE_VLD = 1'b0; ACC_IN = '0; DOUT_RDY = 1'b1; CLR_FLAGS = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_acc_clr", 48'(ACC_CLR), 48'd1);
    check("reset_dout_vld", 48'(DOUT_VLD), 48'd0);
    RST = 1'b0;
    chk_en = 1'b1;

    // Counter and single capture latency.
    tick(1'b1, 48'h5000);
    check("clr_after_1st", 48'(ACC_CLR), 48'd0);
    tick(1'b1, 48'h5000);
    tick(1'b1, 48'h5000);
    tick(1'b1, 48'h5000);
    check("clr_after_4th", 48'(ACC_CLR), 48'd1);
    for (int i = 0; i < 3; i++) tick(1'b0, 48'h5000);
    check("lat_not_yet", 48'(DOUT_VLD), 48'd0);
    tick(1'b0, 48'h5000);
    check("lat_vld", 48'(DOUT_VLD), 48'd1);
    check("lat_dout", 48'(DOUT), 48'h50);
    for (int i = 0; i < 3; i++) tick(1'b0, 48'h0);
    check("one_capture", 48'(DOUT_VLD), 48'd0);

    // Rounding / saturation vectors, flags cleared on each block's first sample.
    for (int k = 0; k < 10; k++) begin
      CLR_FLAGS = 1'b1;
      tick(1'b1, vt[k].acc);
      CLR_FLAGS = 1'b0;
      for (int i = 1; i < TAPS; i++) tick(1'b1, vt[k].acc);
      for (int i = 0; i < 3; i++) tick(1'b0, vt[k].acc);
      check($sformatf("vec%0d_early", k), 48'(DOUT_VLD), 48'd0);
      tick(1'b0, vt[k].acc);
      check($sformatf("vec%0d_vld", k), 48'(DOUT_VLD), 48'd1);
      check($sformatf("vec%0d_dout", k), 48'(DOUT), 48'(vt[k].dout));
      check($sformatf("vec%0d_sat", k), 48'(SAT_FLAG), 48'(vt[k].sat));
      tick(1'b0, 48'h0);
    end

    // CLR_FLAGS alone, then coincident with a sat event.
    CLR_FLAGS = 1'b1;
    tick(1'b0, 48'h0);
    CLR_FLAGS = 1'b0;
    check("clr_alone", 48'(SAT_FLAG), 48'd0);
    block(48'hFFFF_C000_0000, 3);
    CLR_FLAGS = 1'b1;
    tick(1'b0, 48'hFFFF_C000_0000);
    CLR_FLAGS = 1'b0;
    check("clr_vs_sat", 48'(SAT_FLAG), 48'd1);
    check("neg_sat_dout", 48'(DOUT), 48'h20000);
    tick(1'b0, 48'h0);

    // Backpressure with a dropped third result.
    CLR_FLAGS = 1'b1;
    tick(1'b0, 48'h0);
    CLR_FLAGS = 1'b0;
    DOUT_RDY = 1'b0;
    block(48'h1000, 5);
    block(48'h2000, 5);
    block(48'h3000, 5);
    check("drop_set", 48'(DROP_FLAG), 48'd1);
    check("bp_head_v1", 48'(DOUT), 48'h10);
    DOUT_RDY = 1'b1;
    tick(1'b0, 48'h0);
    check("bp_v2", 48'(DOUT), 48'h20);
    check("bp_v2_vld", 48'(DOUT_VLD), 48'd1);
    tick(1'b0, 48'h0);
    check("bp_no_v3", 48'(DOUT_VLD), 48'd0);

    // Full buffer, push and pop in the same cycle.
    CLR_FLAGS = 1'b1;
    tick(1'b0, 48'h0);
    CLR_FLAGS = 1'b0;
    DOUT_RDY = 1'b0;
    block(48'h1000, 5);
    block(48'h2000, 5);
    block(48'h3000, 3);
    DOUT_RDY = 1'b1;
    tick(1'b0, 48'h3000);
    DOUT_RDY = 1'b0;
    check("full_pushpop_nodrop", 48'(DROP_FLAG), 48'd0);
    check("full_pushpop_head", 48'(DOUT), 48'h20);
    DOUT_RDY = 1'b1;
    tick(1'b0, 48'h0);
    check("full_pushpop_v3", 48'(DOUT), 48'h30);
    tick(1'b0, 48'h0);
    check("full_pushpop_empty", 48'(DOUT_VLD), 48'd0);

    // Streaming: 40 back-to-back samples, ramp on ACC_IN.
    p0 = pops;
    for (int i = 0; i < 40; i++) tick(1'b1, 48'(i) * 48'h3_0101);
    for (int i = 0; i < 8; i++) tick(1'b0, 48'h0);
    check("stream_count", 48'(pops - p0), 48'd10);

    // Asynchronous reset with cnt=2, a token in flight and one buffered entry.
    DOUT_RDY = 1'b0;
    block(48'h7000, 6);
    for (int i = 0; i < 6; i++) tick(1'b1, 48'h7000);
    SAMPLE_VLD = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    check("arst_acc_clr", 48'(ACC_CLR), 48'd1);
    check("arst_dout_vld", 48'(DOUT_VLD), 48'd0);
    check("arst_dout", 48'(DOUT), 48'd0);
    check("arst_sat", 48'(SAT_FLAG), 48'd0);
    check("arst_drop", 48'(DROP_FLAG), 48'd0);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    DOUT_RDY = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b0, 48'h7000);
    check("arst_no_stale", 48'(DOUT_VLD), 48'd0);
    for (int i = 0; i < 3; i++) tick(1'b1, 48'h9000);
    for (int i = 0; i < 6; i++) tick(1'b0, 48'h9000);
    check("arst_3_samples", 48'(DOUT_VLD), 48'd0);
    tick(1'b1, 48'h9000);
    for (int i = 0; i < 4; i++) tick(1'b0, 48'h9000);
    check("arst_4th_vld", 48'(DOUT_VLD), 48'd1);
    check("arst_4th_dout", 48'(DOUT), 48'h90);
    tick(1'b0, 48'h0);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      r64 = {$urandom, $urandom};
      DOUT_RDY  = ($urandom % 3) != 0;
      CLR_FLAGS = ($urandom % 16) == 0;
      if ($urandom % 2) tick(($urandom % 4) != 0, r64[47:0]);
      else tick(($urandom % 4) != 0, {{22{r64[25]}}, r64[25:0]});
    end
    CLR_FLAGS = 1'b0;
    DOUT_RDY  = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0, 48'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/macc_dump_sat.md
Name: macc_dump_sat

Overview:
Downstream stage of the 18x18 DSP48E multiply-accumulate block. Counts accepted MAC samples and, once a block of TAPS products has settled, captures the 48-bit accumulator. Rounds, shifts and saturates the captured value to an OUT_W-bit signed result. Delivers results through a 2-entry valid/ready output buffer and tells the MAC when to start a new sum.

Parameters:
TAPS, 16, samples per accumulation block (>=1)
MACC_LAT, 3, cycles from SAMPLE_VLD until ACC_IN reflects that sample (>=1)
SHIFT, 17, right shift applied after rounding (1..46)
OUT_W, 18, signed output width (2..48-SHIFT)
CNT_W, 8, sample counter width (2^CNT_W >= TAPS)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
SAMPLE_VLD  in  1  MAC accepted an A_IN/B_IN pair this cycle
ACC_IN  in  48  accumulator value (MAC PROD_OUT), signed two's complement
ACC_CLR  out  1  high = next SAMPLE_VLD must load, not accumulate (start of new block)
DOUT  out  OUT_W  rounded/saturated result, signed
DOUT_VLD  out  1  DOUT holds a valid result
DOUT_RDY  in  1  consumer accepts DOUT
SAT_FLAG  out  1  sticky: a result was saturated
DROP_FLAG  out  1  sticky: a result was lost because the buffer was full
CLR_FLAGS  in  1  clears SAT_FLAG and DROP_FLAG

Behaviour:
- Reset (async, any time, including mid-block): cnt=0, delay line empty, pipeline empty, buffer empty. ACC_CLR=1, DOUT=0, DOUT_VLD=0, SAT_FLAG=0, DROP_FLAG=0. In-flight tokens are discarded.
- Sample counter: cnt increments on SAMPLE_VLD. When SAMPLE_VLD arrives with cnt==TAPS-1, cnt wraps to 0 and a token enters a MACC_LAT-deep shift register.
- ACC_CLR = registered (cnt==0). With TAPS=1 it is constantly 1.
- The delay line holds multiple tokens, so back-to-back blocks are supported. No sample is lost when SAMPLE_VLD arrives every cycle.
- Capture (cycle the token exits the delay line), stage 1: register r1 = sign-extend49(ACC_IN) + 2^(SHIFT-1). This is round-half-up, so -0.5 LSB rounds to 0.
- Stage 2: s = r1 >>> SHIFT (arithmetic shift).
  - If s > 2^(OUT_W-1)-1, result = max and a sat event fires.
  - If s < -2^(OUT_W-1), result = min and a sat event fires.
  - Otherwise result = s[OUT_W-1:0].
- Latency: ACC_IN sampled at capture appears on DOUT 2 cycles later when the buffer is empty (DOUT_VLD rises on the 2nd edge after capture).
- Output buffer: 2-entry FIFO, first-in first-out.
  - DOUT/DOUT_VLD come from the head entry, registered.
  - Pop when DOUT_VLD & DOUT_RDY.
  - Push when stage 2 is valid.
  - Push with pop in the same cycle is legal at every occupancy, including full.
  - Push while full with no pop: the result is discarded, DROP_FLAG is set, and existing entries are untouched.
  - DOUT holds its value while DOUT_VLD & !DOUT_RDY.
  - DOUT returns to 0 when the buffer is empty.
- Pipeline stages 1-2 never stall. Backpressure only causes drops.
- Sticky flags: set-wins. A sat or drop event in the same cycle as CLR_FLAGS leaves that flag set. Otherwise CLR_FLAGS clears both flags on the next edge.

Decomposition:
- Package macc_pkg:
  - ACC_W=48 constant.
  - round_sat function (value, SHIFT, OUT_W -> result, sat bit).
  - Shared with other MAC-path blocks.
- One sub-module: fifo2_vr, a 2-entry valid/ready FIFO parameterised by width, carrying the full/push-drop indication.
- Counter, delay line and round/sat pipeline live in the top module.

Test Plan:
(Bench parameters: TAPS=4, MACC_LAT=3, SHIFT=8, OUT_W=18, DOUT_RDY=1 unless stated.)
- Reset/counter: after RST, ACC_CLR=1 and DOUT_VLD=0. Send 4 SAMPLE_VLD pulses -> ACC_CLR=0 after the 1st and 1 again after the 4th. Exactly one capture, 3 cycles after the 4th pulse.
- Rounding: ACC_IN=0x000000012380 at capture -> DOUT=0x00124, DOUT_VLD 2 cycles later, SAT_FLAG=0. ACC_IN=0xFFFFFFFFFF80 (-128) -> DOUT=0x00000. ACC_IN=0xFFFFFFFFFF7F (-129) -> DOUT=0x3FFFF.
- Saturation: ACC_IN=0x000040000000 -> DOUT=0x1FFFF, SAT_FLAG=1. ACC_IN=0xFFFFC0000000 -> DOUT=0x20000. Assert CLR_FLAGS alone -> SAT_FLAG=0. CLR_FLAGS coincident with a sat event -> SAT_FLAG stays 1.
- Backpressure/drop: DOUT_RDY=0, then three captures with distinct values V1, V2, V3 -> DROP_FLAG=1. Raise DOUT_RDY -> V1 then V2 emerge, V3 never appears. Full buffer with simultaneous push and pop -> no drop.
- Streaming: SAMPLE_VLD high for 40 consecutive cycles with a ramp on ACC_IN -> exactly 10 results, in order, each equal to round_sat of ACC_IN at its capture cycle.
- Reset mid-operation: assert RST asynchronously (not on an edge) with cnt=2, one token in the delay line and one buffer entry -> all outputs at reset values immediately. After release, no stale result appears and the next block needs 4 fresh samples.
